pll_cfg_seq: RTL and testbench

- Configuration and lock sequencer that drives the control pins of the PLL600 macro and consumes its LKDET output.
- Takes 16-bit pllconf writes from the control register block and applies them with a safe power-down/relock sequence.
- Reports lock state, lock loss and lock timeout.
- Sits between the control register file and the PLL instance, clocked by the PLL reference clock.

---
 rtl/pll_cfg_seq_if.sv | 35 +++
 rtl/pll_cfg_seq.sv | 187 ++++++++++++++++++
 tb/tb_pll_cfg_seq.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_cfg_seq_if.sv
// pll_cfg_seq_if: register-block write port plus PLL600 control/status pins.
// slave is the sequencer side, master is the register block / PLL side.
interface pll_cfg_seq_if;
    logic        WR;
    logic [15:0] WDATA;
    logic        SLOW_MEM_REQ;
    logic        LKDET;
    logic        WR_NACK;
    logic        SYNCEN;
    logic        SG1;
    logic        TM1;
    logic        TM2;
    logic [4:0]  CHP;
    logic [1:0]  VCOD;
    logic [4:0]  DIV;
    logic        SLOW_MEM;
    logic        PD;
    logic        ENB;
    logic        BUSY;
    logic        LOCKED;
    logic        LOSS;
    logic        TIMEOUT_ERR;

    modport master (
        output WR, WDATA, SLOW_MEM_REQ, LKDET,
        input  WR_NACK, SYNCEN, SG1, TM1, TM2, CHP, VCOD, DIV,
        input  SLOW_MEM, PD, ENB, BUSY, LOCKED, LOSS, TIMEOUT_ERR
    );

    modport slave (
        input  WR, WDATA, SLOW_MEM_REQ, LKDET,
        output WR_NACK, SYNCEN, SG1, TM1, TM2, CHP, VCOD, DIV,
        output SLOW_MEM, PD, ENB, BUSY, LOCKED, LOSS, TIMEOUT_ERR
    );
endinterface

// File: rtl/pll_cfg_seq.sv
// pll_cfg_seq: PLL600 config apply / power-cycle / lock sequencer on BMCLK1X.
// Define PLL_CFG_SEQ_BYPASS_EN to force TM2 high everywhere except S_LOCKED.
module pll_cfg_seq #(
    parameter logic [15:0] RESET_CFG   = 16'h0000,
    parameter int          PD_CYC      = 16,
    parameter int          BLANK_CYC   = 4,
    parameter int          LOCK_FILT   = 8,
    parameter int          TIMEOUT_CYC = 256
) (
    input  logic         BMCLK1X,
    input  logic         RST,
    pll_cfg_seq_if.slave pll
);

    localparam logic [15:0] L_PD_LAST = 16'(PD_CYC - 1);
    localparam logic [15:0] L_BLANK   = 16'(BLANK_CYC);
    localparam logic [15:0] L_FILT    = 16'(LOCK_FILT);
    localparam logic [15:0] L_TO_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_PD,
        S_WAIT_LOCK,
        S_LOCKED,
        S_APPLY,
        S_FAIL
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic [15:0] r_filt;
    logic        r_lk_meta;
    logic        r_lk_s;
    logic [15:0] r_cfg;
    logic        r_slow;
    logic [15:0] r_pend;
    logic        r_pend_sm;
    logic        r_nack;
    logic        r_loss;
    logic        r_to;
    logic        w_pd;
    logic        w_busy;
    logic        w_locked;
    logic        w_tm2;
    logic        w_vcod_chg;
    logic        w_wr_busy;

    assign w_vcod_chg = (r_pend[6:5] != r_cfg[6:5]);
    assign w_wr_busy  = pll.WR && (r_state == S_PD ||
                                   r_state == S_WAIT_LOCK ||
                                   r_state == S_APPLY);

    always_ff @(posedge BMCLK1X or posedge RST) begin
        if (RST) begin
            r_lk_meta <= 1'b0;
            r_lk_s    <= 1'b0;
        end else begin
            r_lk_meta <= pll.LKDET;
            r_lk_s    <= r_lk_meta;
        end
    end

    always_ff @(posedge BMCLK1X or posedge RST) begin
        if (RST) begin
            r_state <= S_PD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_PD: begin
                if (r_cnt == L_PD_LAST) w_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // lock outranks timeout on the same cycle
                if (r_filt == L_FILT)         w_next = S_LOCKED;
                else if (r_cnt == L_TO_LAST)  w_next = S_FAIL;
            end
            S_LOCKED: begin
                if (pll.WR)       w_next = S_APPLY;
                else if (!r_lk_s) w_next = S_WAIT_LOCK;
            end
            S_APPLY: begin
                w_next = w_vcod_chg ? S_PD : S_WAIT_LOCK;
            end
            S_FAIL: begin
                if (pll.WR) w_next = S_PD;
            end
            default: w_next = S_PD;
        endcase
    end

    always_comb begin
        w_pd     = 1'b0;
        w_busy   = 1'b0;
        w_locked = 1'b0;
        unique case (r_state)
            S_PD: begin
                w_pd   = 1'b1;
                w_busy = 1'b1;
            end
            S_WAIT_LOCK: w_busy   = 1'b1;
            S_APPLY:     w_busy   = 1'b1;
            S_LOCKED:    w_locked = 1'b1;
            S_FAIL:      w_pd     = 1'b1;
            default:     w_pd     = 1'b1;
        endcase
    end

`ifdef PLL_CFG_SEQ_BYPASS_EN
    assign w_tm2 = w_locked ? r_cfg[13] : 1'b1;
`else
    assign w_tm2 = r_cfg[13];
`endif

    always_ff @(posedge BMCLK1X or posedge RST) begin
        if (RST) begin
            r_cnt  <= '0;
            r_filt <= '0;
        end else begin
            r_cnt <= (w_next != r_state) ? '0 : r_cnt + 16'd1;
            if (r_state != S_WAIT_LOCK || r_cnt < L_BLANK) begin
                r_filt <= '0;
            end else begin
                r_filt <= r_lk_s ? r_filt + 16'd1 : '0;
            end
        end
    end

    always_ff @(posedge BMCLK1X or posedge RST) begin
        if (RST) begin
            r_cfg     <= RESET_CFG;
            r_slow    <= 1'b0;
            r_pend    <= RESET_CFG;
            r_pend_sm <= 1'b0;
            r_nack    <= 1'b0;
            r_loss    <= 1'b0;
            r_to      <= 1'b0;
        end else begin
            r_nack <= w_wr_busy;
            // hold the write so WDATA need not stay valid into S_APPLY
            if (r_state == S_LOCKED && pll.WR) begin
                r_pend    <= pll.WDATA;
                r_pend_sm <= pll.SLOW_MEM_REQ;
            end
            if (r_state == S_APPLY) begin
                r_cfg  <= r_pend;
                r_slow <= r_pend_sm;
            end
            if (r_state == S_FAIL && pll.WR) begin
                r_cfg  <= pll.WDATA;
                r_slow <= pll.SLOW_MEM_REQ;
            end
            if (r_state == S_LOCKED && !r_lk_s) begin
                r_loss <= 1'b1;
            end else if (pll.WR && (r_state == S_LOCKED ||
                                    r_state == S_FAIL)) begin
                r_loss <= 1'b0;
            end
            if (r_state == S_WAIT_LOCK && w_next == S_FAIL) begin
                r_to <= 1'b1;
            end else if (r_state == S_FAIL && pll.WR) begin
                r_to <= 1'b0;
            end
        end
    end

    assign pll.SYNCEN      = r_cfg[15];
    assign pll.SG1         = r_cfg[14];
    assign pll.TM2         = w_tm2;
    assign pll.TM1         = r_cfg[12];
    assign pll.CHP         = r_cfg[11:7];
    assign pll.VCOD        = r_cfg[6:5];
    assign pll.DIV         = r_cfg[4:0];
    assign pll.SLOW_MEM    = r_slow;
    assign pll.PD          = w_pd;
    assign pll.ENB         = w_pd;
    assign pll.BUSY        = w_busy;
    assign pll.LOCKED      = w_locked;
    assign pll.LOSS        = r_loss;
    assign pll.TIMEOUT_ERR = r_to;
    assign pll.WR_NACK     = r_nack;

endmodule

// File: tb/tb_pll_cfg_seq.sv
// tb_pll_cfg_seq: directed bench for pll_cfg_seq with an expectation queue.
// Covers power-up, DIV-only relock, VCOD power cycle, timeout, NACK, glitch.
module tb_pll_cfg_seq;

    localparam logic [15:0] RCFG = 16'h0003;
`ifdef PLL_CFG_SEQ_BYPASS_EN
    localparam logic TM2_BUSY = 1'b1;
`else
    localparam logic TM2_BUSY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    pll_cfg_seq_if ifc ();

    pll_cfg_seq #(
        .RESET_CFG (RCFG)
    ) dut (
        .BMCLK1X (clk),
        .RST     (rst),
        .pll     (ifc.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL queue_empty: observed %0h required entry", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0h required %0h",
                       e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic count_pd(output int n);
        n = 0;
        while (ifc.PD === 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (ifc.LOCKED !== 1'b1 && n < 600) begin
            n++;
            step();
        end
    endtask

    initial begin
        int   n;
        int   m;
        int   k;
        logic saw_pd;
        logic saw_busy;

        rst              = 1'b1;
        ifc.WR           = 1'b0;
        ifc.WDATA        = 16'h0000;
        ifc.SLOW_MEM_REQ = 1'b0;
        ifc.LKDET        = 1'b1;
        step(3);

        push("rst_pd", 1);
        push("rst_enb", 1);
        push("rst_busy", 1);
        push("rst_locked", 0);
        push("rst_loss", 0);
        push("rst_timeout", 0);
        push("rst_nack", 0);
        push("rst_div", 3);
        push("rst_slowmem", 0);
        push("rst_tm2", TM2_BUSY);
        chk(ifc.PD);
        chk(ifc.ENB);
        chk(ifc.BUSY);
        chk(ifc.LOCKED);
        chk(ifc.LOSS);
        chk(ifc.TIMEOUT_ERR);
        chk(ifc.WR_NACK);
        chk(ifc.DIV);
        chk(ifc.SLOW_MEM);
        chk(ifc.TM2);

        // power-up with LKDET tied high
        rst = 1'b0;
        push("pwrup_pd_width", 16);
        push("pwrup_enb_low", 0);
        push("pwrup_tm2_wait", TM2_BUSY);
        push("pwrup_lock_time", 1);
        push("pwrup_div", 3);
        push("pwrup_busy", 0);
        push("pwrup_tm2_locked", 0);
        count_pd(n);
        chk(n);
        chk(ifc.ENB);
        chk(ifc.TM2);
        wait_lock(m);
        chk((n + m) >= 29 && (n + m) <= 31);
        chk(ifc.DIV);
        chk(ifc.BUSY);
        chk(ifc.TM2);

        // DIV-only write, PLL drops LKDET for 20 cycles
        ifc.WDATA        = 16'h0005;
        ifc.SLOW_MEM_REQ = 1'b1;
        ifc.WR           = 1'b1;
        ifc.LKDET        = 1'b0;
        push("div_value", 5);
        push("div_slowmem", 1);
        push("div_no_pd", 0);
        push("div_busy", 1);
        push("div_relock", 1);
        push("div_loss", 0);
        step();
        ifc.WR           = 1'b0;
        ifc.SLOW_MEM_REQ = 1'b0;
        saw_pd   = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 19; i++) begin
            saw_pd   = saw_pd | ifc.PD;
            saw_busy = saw_busy | ifc.BUSY;
            step();
        end
        ifc.LKDET = 1'b1;
        wait_lock(m);
        chk(ifc.DIV);
        chk(ifc.SLOW_MEM);
        chk(saw_pd);
        chk(saw_busy);
        chk(ifc.LOCKED);
        chk(ifc.LOSS);

        // VCOD 0 -> 2 forces a power cycle
        ifc.WDATA = 16'h0040;
        ifc.WR    = 1'b1;
        push("vcod_pd_width", 16);
        push("vcod_value", 2);
        push("vcod_div", 0);
        push("vcod_relock", 1);
        step();
        ifc.WR = 1'b0;
        step();
        count_pd(n);
        chk(n);
        wait_lock(m);
        chk(ifc.VCOD);
        chk(ifc.DIV);
        chk(ifc.LOCKED);

        // LKDET held low: loss, then timeout
        ifc.LKDET = 1'b0;
        push("to_loss", 1);
        push("to_wait_cycles", 256);
        push("to_err", 1);
        push("to_pd", 1);
        push("to_enb", 1);
        push("to_busy", 0);
        n = 0;
        while (ifc.BUSY !== 1'b1 && n < 10) begin
            n++;
            step();
        end
        chk(ifc.LOSS);
        m = 0;
        k = 0;
        while (ifc.TIMEOUT_ERR !== 1'b1 && k < 400) begin
            if (ifc.BUSY === 1'b1) m++;
            k++;
            step();
        end
        chk(m);
        chk(ifc.TIMEOUT_ERR);
        chk(ifc.PD);
        chk(ifc.ENB);
        chk(ifc.BUSY);

        // write in S_FAIL restarts the sequence
        ifc.WDATA = 16'h0003;
        ifc.WR    = 1'b1;
        ifc.LKDET = 1'b1;
        push("fail_wr_timeout", 0);
        push("fail_wr_loss", 0);
        push("fail_wr_pd", 1);
        push("fail_wr_busy", 1);
        push("fail_wr_div", 3);
        push("fail_wr_nack", 0);
        step();
        ifc.WR = 1'b0;
        chk(ifc.TIMEOUT_ERR);
        chk(ifc.LOSS);
        chk(ifc.PD);
        chk(ifc.BUSY);
        chk(ifc.DIV);
        chk(ifc.WR_NACK);

        // write during S_WAIT_LOCK is rejected
        push("nack_pd_width", 16);
        count_pd(n);
        chk(n);
        ifc.WDATA = 16'hFFFF;
        ifc.WR    = 1'b1;
        push("nack_pulse", 1);
        push("nack_div_keep", 3);
        push("nack_chp_keep", 0);
        push("nack_syncen_keep", 0);
        push("nack_tm2", TM2_BUSY);
        push("nack_one_cycle", 0);
        push("nack_relock", 1);
        push("nack_relock_div", 3);
        step();
        ifc.WR = 1'b0;
        chk(ifc.WR_NACK);
        chk(ifc.DIV);
        chk(ifc.CHP);
        chk(ifc.SYNCEN);
        chk(ifc.TM2);
        step();
        chk(ifc.WR_NACK);
        wait_lock(m);
        chk(ifc.LOCKED);
        chk(ifc.DIV);

        // 3-cycle LKDET glitch in S_LOCKED
        ifc.LKDET = 1'b0;
        push("glitch_unlock", 0);
        push("glitch_loss", 1);
        push("glitch_relock", 1);
        push("glitch_tm2", 0);
        step(3);
        ifc.LKDET = 1'b1;
        chk(ifc.LOCKED);
        wait_lock(m);
        chk(ifc.LOSS);
        chk(ifc.LOCKED);
        chk(ifc.TM2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
